// File: rtl/circuito_latch_if.sv
// Bus bundle for the circuito_latch storage stage: the data word to capture,
// the load select, and the stored word coming back.
interface circuito_latch_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] entradas;
  logic             sel;
  logic [WIDTH-1:0] salidas;

  // Data source side: drives the word and the select, observes the stored word.
  modport master (
    output entradas,
    output sel,
    input  salidas
  );

  // Storage side: samples the word and the select, drives the stored word.
  modport slave (
    input  entradas,
    input  sel,
    output salidas
  );
endinterface

// File: rtl/circuito_latch.sv
// Selectable storage register: on each rising clk edge the stored word either
// loads entradas (sel = 1) or holds (sel = 0). The output comes straight from
// the flops, so it never follows entradas between edges. rst clears the word
// asynchronously and overrides any load on a coincident edge.
module circuito_latch #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  circuito_latch_if.slave  bus
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next stored word: whole-word load when selected, otherwise recirculate.
  always_comb begin
    data_d = data_q;
    if (bus.sel) begin
      data_d = bus.entradas;
    end
  end

  // Storage flops; asynchronous reset wins over a load on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.salidas = data_q;

endmodule

// File: tb/tb_circuito_latch.sv
// Directed bench for circuito_latch: reset behaviour, load/hold alternation,
// hold stability, no transparent path, async reset mid-run, and a reset that
// coincides with a load edge. Inputs change on the falling edge; outputs are
// sampled 1 ns after the rising edge or at chosen points between edges.
`timescale 1ns/1ps
module tb_circuito_latch;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  circuito_latch_if #(.WIDTH(WIDTH)) bus ();

  circuito_latch #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 200 ns clock period.
  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] expected);
    n_checks++;
    assert (bus.salidas === expected)
    else begin
      n_fail++;
      $error("FAIL %s: salidas=%h expected=%h", tag, bus.salidas, expected);
    end
  endtask

  task automatic load_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.entradas = 4'hF;
    bus.sel      = 1'b1;

    // Reset asserted with a load pending: output cleared and held across edges.
    #1;
    check("reset_async", 4'h0);
    for (int i = 0; i < 3; i++) begin
      load_edge();
      check("reset_hold", 4'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    load_edge();
    check("reset_release_load", 4'hF);

    // Load/hold alternation: 9,9 then 5 then 4 with sel toggling from 1.
    @(negedge clk);
    bus.sel = 1'b1; bus.entradas = 4'h9;
    load_edge();
    check("alt_load9", 4'h9);
    @(negedge clk);
    bus.sel = 1'b0;
    load_edge();
    check("alt_hold9", 4'h9);
    @(negedge clk);
    bus.sel = 1'b1; bus.entradas = 4'h5;
    load_edge();
    check("alt_load5", 4'h5);
    @(negedge clk);
    bus.sel = 1'b0; bus.entradas = 4'h4;
    load_edge();
    check("alt_hold5", 4'h5);
    @(negedge clk);
    bus.sel = 1'b1;
    load_edge();
    check("alt_load4", 4'h4);

    // Hold stability while entradas sweeps the full range.
    @(negedge clk);
    bus.entradas = 4'hA;
    load_edge();
    check("hold_loadA", 4'hA);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.sel      = 1'b0;
      bus.entradas = 4'(i);
      load_edge();
      check("hold_sweep", 4'hA);
    end

    // Mid-cycle input change with sel = 1 never reaches the output.
    @(negedge clk);
    bus.sel = 1'b1; bus.entradas = 4'h3;
    #20 bus.entradas = 4'hC;
    #1 check("midcycle_no_transp", 4'hA);
    #20 bus.entradas = 4'h3;
    load_edge();
    check("midcycle_load3", 4'h3);
    @(negedge clk);
    bus.entradas = 4'hC;
    #10 check("midcycle_no_transp2", 4'h3);
    bus.entradas = 4'h3;
    load_edge();
    check("midcycle_keep3", 4'h3);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    bus.entradas = 4'h7;
    load_edge();
    check("async_pre7", 4'h7);
    #30 rst = 1'b1;
    #1 check("async_clear", 4'h0);
    #29 rst = 1'b0;
    #1 check("async_after_release", 4'h0);
    @(negedge clk);
    bus.entradas = 4'h2;
    load_edge();
    check("async_reload", 4'h2);

    // Reset rising on the same edge as a load of 6.
    @(negedge clk);
    bus.sel = 1'b1; bus.entradas = 4'h6;
    @(posedge clk);
    rst = 1'b1;
    #1 check("coincident_reset", 4'h0);
    @(negedge clk);
    rst = 1'b0; bus.sel = 1'b0;
    load_edge();
    check("coincident_hold0", 4'h0);
    @(negedge clk);
    bus.sel = 1'b1;
    load_edge();
    check("coincident_reload6", 4'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
